// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined ripple-carry adder:
// default sizes, the WIDTH/STAGES legality check and the chunk-index helper.
package pipe_add_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;

   // True when WIDTH splits into STAGES equal, non-empty chunks.
   function automatic bit width_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

   // Bit index of the least significant bit of chunk k.
   function automatic int chunk_lo(input int k, input int chunk);
      return k * chunk;
   endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module add_chunk #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb
);

   logic [W:0] c;

   assign c[0] = cin;

   for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
   end

   assign co    = c[W];
   assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: operands split into STAGES chunks, one chunk
// added per stage with the carry registered between stages. A global stall
// (adv) freezes every stage whenever the output holds a result nobody takes.
// Optional feature macro: PIPE_ADD_OVF_EN enables the signed-overflow output;
// without it ovf is tied to 0.
module pipelined_ripple_adder
   import pipe_add_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CHUNK = WIDTH / STAGES;

   if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
   end

   logic             adv;

   // Stage state: valid bit, operand skew copies, partial sum, chunk carry.
   logic             valid_q [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             carry_q [STAGES];

   // Per-stage inputs and adder results.
   logic             vin     [STAGES];
   logic [WIDTH-1:0] opa     [STAGES];
   logic [WIDTH-1:0] opb     [STAGES];
   logic [WIDTH-1:0] base    [STAGES];
   logic             cin_s   [STAGES];
   logic [CHUNK-1:0] s_s     [STAGES];
   logic             co_s    [STAGES];
   logic             msb_s   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];

   assign adv      = out_ready | ~valid_q[STAGES-1];
   assign in_ready = adv;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = chunk_lo(gi, CHUNK);

      if (gi == 0) begin : g_first
         assign vin[gi]   = in_valid;
         assign opa[gi]   = a;
         assign opb[gi]   = b;
         assign cin_s[gi] = cin;
         assign base[gi]  = '0;
      end else begin : g_next
         assign vin[gi]   = valid_q[gi-1];
         assign opa[gi]   = a_q[gi-1];
         assign opb[gi]   = b_q[gi-1];
         assign cin_s[gi] = carry_q[gi-1];
         assign base[gi]  = sum_q[gi-1];
      end

      add_chunk #(.W(CHUNK)) u_add (
         .a     (opa[gi][LO +: CHUNK]),
         .b     (opb[gi][LO +: CHUNK]),
         .cin   (cin_s[gi]),
         .s     (s_s[gi]),
         .co    (co_s[gi]),
         .c_msb (msb_s[gi])
      );

      // Chunks at and above gi are still zero in base, so OR inserts this chunk.
      assign sum_d[gi] = base[gi] | (WIDTH'(s_s[gi]) << LO);
   end

   // Shift all stages together on adv; bubbles leave data registers untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= vin[k];
            if (vin[k]) begin
               a_q[k]     <= opa[k];
               b_q[k]     <= opb[k];
               sum_q[k]   <= sum_d[k];
               carry_q[k] <= co_s[k];
            end
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];

`ifdef PIPE_ADD_OVF_EN
   logic ovf_q;

   // Signed overflow of the result entering the last stage, held with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv && vin[STAGES-1]) begin
         ovf_q <= msb_s[STAGES-1] ^ co_s[STAGES-1];
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (WIDTH=16, STAGES=4).
// Expected results are queued on input transfer and compared on output transfer.
module tb_pipelined_ripple_adder;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   typedef logic [WIDTH+1:0] res_t;   // {ovf, cout, sum}

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             out_valid;
   logic             out_ready = 1'b1;

   res_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_out    = 0;
   int   run_len  = 0;
   int   max_run  = 0;
   bit   hold_v   = 1'b0;
   res_t hold_r   = '0;

   pipelined_ripple_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                  input logic tc);
      logic [WIDTH:0] full;
      logic           ov;
      full = {1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tc};
`ifdef PIPE_ADD_OVF_EN
      ov = (ta[WIDTH-1] == tb_[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
`else
      ov = 1'b0;
`endif
      return {ov, full[WIDTH], full[WIDTH-1:0]};
   endfunction

   // Monitor: handshakes are stable at the falling edge and fire at the next rising edge.
   always @(negedge clk) begin
      res_t exp;
      if (!rst_n) begin
         sb.delete();
         hold_v  = 1'b0;
         run_len = 0;
      end else begin
         if (hold_v) begin
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_hold", {14'd0, ovf, cout, sum}, {14'd0, hold_r});
         end
         hold_v = out_valid && !out_ready;
         hold_r = {ovf, cout, sum};
         if (out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
               exp = sb.pop_front();
               check_eq("result", {14'd0, ovf, cout, sum}, {14'd0, exp});
               $display("out #%0d: sum=%h cout=%b ovf=%b", n_out, sum, cout, ovf);
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin));
            $display("in: a=%h b=%h cin=%b", a, b, cin);
         end
      end
   end

   // Drive one operand set and hold it until accepted; inputs go X afterwards.
   task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
      int guard = 0;
      a = ta;
      b = tb_;
      cin = tc;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      if (!in_ready) check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 'x;
      b = 'x;
      cin = 1'bx;
   endtask

   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while ((sb.size() != 0 || out_valid) && guard < 100) begin
         guard++;
         @(negedge clk);
      end
      check_eq("drain", sb.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int out_base;

      // Reset then idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_sum", {16'd0, sum}, 32'd0);
      check_eq("rst_cout", {31'd0, cout}, 32'd0);
      check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Carry across all chunks, with latency measurement
      out_ready = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check_eq("latency", lat, STAGES);
      @(posedge clk);
      #1;
      send(16'h1234, 16'h4321, 1'b1);
      wait_idle();

      // Back-to-back throughput
      max_run  = 0;
      out_base = n_out;
      for (int i = 0; i < 8; i++) begin
         logic [WIDTH-1:0] iv;
         iv = WIDTH'(i);
         send(iv, WIDTH'(i * 3), iv[0]);
      end
      wait_idle();
      check_eq("b2b_run", max_run, 32'd8);
      check_eq("b2b_count", n_out - out_base, 32'd8);

      // Backpressure: fill the pipe, stall five cycles, then drain
      out_ready = 1'b0;
      out_base  = n_out;
      for (int i = 0; i < 4; i++) begin
         send(WIDTH'(16'hA000 + i * 16'h0111), WIDTH'(16'h7000 + i * 16'h1F0F), 1'(i));
      end
      repeat (5) begin
         @(negedge clk);
         check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'h00FF, 16'hFF01, 1'b1);
      send(16'hC3C3, 16'h3C3C, 1'b0);
      wait_idle();
      check_eq("bp_count", n_out - out_base, 32'd6);

      // Reset with three results in flight
      send(16'h1111, 16'h2222, 1'b0);
      send(16'h3333, 16'h4444, 1'b1);
      send(16'h5555, 16'h6666, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("post_reset_valid", {31'd0, out_valid}, 32'd0);
      end
      check_eq("post_reset_sb", sb.size(), 32'd0);
      @(posedge clk);
      #1;

      // Signed overflow corners
      send(16'h7FFF, 16'h0001, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h8000, 16'h7FFF, 1'b1);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
